// File: rtl/acorn128_pkg.sv
// acorn128_pkg: shared constants, phase encoding and boolean helpers for the ACORN-128 datapath
package acorn128_pkg;
  localparam int STATE_W = 293;
  localparam int AD_BITS = 128;
  localparam int TEXT_BITS = 128;
  localparam int PAD_STEPS = 256;
  localparam int FINAL_STEPS = 768;
  localparam int TAG_BITS = 128;
  localparam logic [10:0] AD_LAST = 11'(AD_BITS - 1);
  localparam logic [10:0] TEXT_LAST = 11'(TEXT_BITS - 1);
  localparam logic [10:0] PAD_LAST = 11'(PAD_STEPS - 1);
  localparam logic [10:0] FINAL_LAST = 11'(FINAL_STEPS - 1);
  localparam logic [10:0] TAG_FIRST = 11'(FINAL_STEPS - TAG_BITS);
  localparam logic [10:0] CA_STEPS = 11'd128;
  typedef enum logic [2:0] {IDLE, AD, AD_PAD, TEXT, TEXT_PAD, FINAL} phase_t;
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction
endpackage

// File: rtl/acorn128_step.sv
// acorn128_step: one combinational ACORN-128 state-update step with keystream bit
module acorn128_step
  import acorn128_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               m,
  input  logic               ca,
  input  logic               cb,
  output logic [STATE_W-1:0] next_state,
  output logic               ks
);
  logic [STATE_W-1:0] t;
  logic f;
  always_comb begin
    t = state;
    t[289] = t[289] ^ t[235] ^ t[230];
    t[230] = t[230] ^ t[196] ^ t[193];
    t[193] = t[193] ^ t[160] ^ t[154];
    t[154] = t[154] ^ t[111] ^ t[107];
    t[107] = t[107] ^ t[66] ^ t[61];
    t[61] = t[61] ^ t[23] ^ t[0];
  end
  // ks never depends on m, so a decrypt-side m = c ^ ks forms no combinational loop
  assign ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
  assign f = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks) ^ m;
  assign next_state = {f, t[STATE_W-1:1]};
endmodule

// File: rtl/acorn128_ad_enc_final.sv
// acorn128_ad_enc_final: AD absorption, one-block encrypt/decrypt and tag finalization,
// one ACORN step per clock after an accepted start.
module acorn128_ad_enc_final
  import acorn128_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic               encrypt_in,
  input  logic [STATE_W-1:0] state_in,
  input  logic [AD_BITS-1:0] ad_in,
  input  logic [TEXT_BITS-1:0] text_in,
  output logic [TEXT_BITS-1:0] text_out,
  output logic [TAG_BITS-1:0] tag_out,
  output logic [STATE_W-1:0] state_out,
  output logic               busy_out,
  output logic               done_out
);
  phase_t phase, phase_nx;
  logic [10:0] cnt;
  logic [AD_BITS-1:0] ad_r;
  logic [TEXT_BITS-1:0] txt_r;
  logic enc_r, m, ca, cb, ks, last;
  logic [6:0] bi;
  logic [STATE_W-1:0] nxt;
  assign bi = cnt[6:0];
  acorn128_step u_step (.state(state_out), .m(m), .ca(ca), .cb(cb), .next_state(nxt), .ks(ks));
  always_ff @(posedge clk or posedge rst)
    if (rst) phase <= IDLE;
    else phase <= phase_nx;
  always_comb begin
    phase_nx = phase;
    m = 1'b0;
    ca = 1'b0;
    cb = 1'b0;
    last = 1'b0;
    case (phase)
      IDLE: phase_nx = start_in ? AD : IDLE;
      AD: begin
        m = ad_r[bi];
        ca = 1'b1;
        cb = 1'b1;
        last = cnt == AD_LAST;
        phase_nx = last ? AD_PAD : AD;
      end
      AD_PAD: begin
        m = cnt == 11'd0;
        ca = cnt < CA_STEPS;
        cb = 1'b1;
        last = cnt == PAD_LAST;
        phase_nx = last ? TEXT : AD_PAD;
      end
      TEXT: begin
        m = enc_r ? txt_r[bi] : txt_r[bi] ^ ks;
        ca = 1'b1;
        last = cnt == TEXT_LAST;
        phase_nx = last ? TEXT_PAD : TEXT;
      end
      TEXT_PAD: begin
        m = cnt == 11'd0;
        ca = cnt < CA_STEPS;
        last = cnt == PAD_LAST;
        phase_nx = last ? FINAL : TEXT_PAD;
      end
      FINAL: begin
        ca = 1'b1;
        cb = 1'b1;
        last = cnt == FINAL_LAST;
        phase_nx = last ? IDLE : FINAL;
      end
      default: phase_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_out <= '0;
      ad_r <= '0;
      txt_r <= '0;
      enc_r <= 1'b0;
      cnt <= '0;
      text_out <= '0;
      tag_out <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else if (phase == IDLE) begin
      if (start_in) begin
        state_out <= state_in;
        ad_r <= ad_in;
        txt_r <= text_in;
        enc_r <= encrypt_in;
        cnt <= '0;
        text_out <= '0;
        tag_out <= '0;
        busy_out <= 1'b1;
        done_out <= 1'b0;
      end
    end else begin
      state_out <= nxt;
      cnt <= last ? 11'd0 : cnt + 11'd1;
      if (phase == TEXT) text_out[bi] <= txt_r[bi] ^ ks;
      // TAG_FIRST is a multiple of 128, so the tag bit index is just the low counter bits
      if (phase == FINAL && cnt >= TAG_FIRST) tag_out[bi] <= ks;
      if (phase == FINAL && last) begin
        busy_out <= 1'b0;
        done_out <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_acorn128_ad_enc_final.sv
// tb_acorn128_ad_enc_final: table-driven vectors against a step-indexed reference model,
// plus directed sequences for zero-state stepping, latency, busy-start and mid-run reset.
module tb_acorn128_ad_enc_final;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_in = 1'b0;
  logic encrypt_in = 1'b0;
  logic [292:0] state_in = '0;
  logic [127:0] ad_in = '0;
  logic [127:0] text_in = '0;
  logic [127:0] text_out, tag_out;
  logic [292:0] state_out;
  logic busy_out, done_out;
  int total = 0;
  int bad = 0;

  acorn128_ad_enc_final dut (
    .clk(clk), .rst(rst), .start_in(start_in), .encrypt_in(encrypt_in),
    .state_in(state_in), .ad_in(ad_in), .text_in(text_in),
    .text_out(text_out), .tag_out(tag_out), .state_out(state_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [292:0] st;
    logic [127:0] ad;
    logic [127:0] tx;
    logic enc;
    logic [127:0] et;
    logic [127:0] eg;
  } vec_t;

  task automatic chk(input string nm, input logic ok, input logic [292:0] got, input logic [292:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  function automatic logic [292:0] rnd293();
    logic [319:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[292:0];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: walks the 1536 steps by global step index
  function automatic void model(input logic [292:0] s0, input logic [127:0] a, input logic [127:0] t,
                                input logic e, output logic [127:0] to, output logic [127:0] tg);
    logic [292:0] s;
    logic k, m, ca, cb, f;
    s = s0;
    to = '0;
    tg = '0;
    for (int i = 0; i < 1536; i++) begin
      s[289] = s[289] ^ s[235] ^ s[230];
      s[230] = s[230] ^ s[196] ^ s[193];
      s[193] = s[193] ^ s[160] ^ s[154];
      s[154] = s[154] ^ s[111] ^ s[107];
      s[107] = s[107] ^ s[66] ^ s[61];
      s[61] = s[61] ^ s[23] ^ s[0];
      k = s[12] ^ s[154] ^ ((s[235] & s[61]) ^ (s[235] & s[193]) ^ (s[61] & s[193]))
          ^ ((s[230] & s[111]) ^ (~s[230] & s[66]));
      if (i < 128) begin
        m = a[i]; ca = 1'b1; cb = 1'b1;
      end else if (i < 384) begin
        m = (i == 128); ca = (i < 256); cb = 1'b1;
      end else if (i < 512) begin
        m = e ? t[i-384] : t[i-384] ^ k;
        to[i-384] = t[i-384] ^ k;
        ca = 1'b1; cb = 1'b0;
      end else if (i < 768) begin
        m = (i == 512); ca = (i < 640); cb = 1'b0;
      end else begin
        m = 1'b0; ca = 1'b1; cb = 1'b1;
        if (i >= 1408) tg[i-1408] = k;
      end
      f = s[0] ^ ~s[107] ^ ((s[244] & s[23]) ^ (s[244] & s[160]) ^ (s[23] & s[160]))
          ^ (ca & s[196]) ^ (cb & k) ^ m;
      s = {f, s[292:1]};
    end
  endfunction

  // lat = edges after the start edge until done rises; -1 if aborted by reset
  task automatic run(input logic [292:0] s, input logic [127:0] a, input logic [127:0] t,
                     input logic e, input int poke, input int abort_at, output int lat);
    @(negedge clk);
    state_in = s; ad_in = a; text_in = t; encrypt_in = e; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    chk("busy_after_start", busy_out == 1'b1 && done_out == 1'b0, 293'(busy_out), 293'(1));
    lat = 0;
    for (int n = 1; n <= 2000; n++) begin
      if (n == poke) begin
        start_in = 1'b1; state_in = ~s; ad_in = ~a; text_in = ~t; encrypt_in = ~e;
      end
      if (n == abort_at) begin
        rst = 1'b1; #1;
        chk("reset_clears", {state_out, text_out, tag_out, busy_out, done_out} == '0,
            293'(state_out | 293'(text_out) | 293'(tag_out)), 293'(0));
        #1 rst = 1'b0;
        lat = -1;
        break;
      end
      @(posedge clk); #1;
      start_in = 1'b0;
      if (done_out) begin
        lat = n;
        chk("busy_low_at_done", busy_out == 1'b0, 293'(busy_out), 293'(0));
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 1'b0, 293'(0), 293'(1536));
  endtask

  vec_t vt[4];
  int lat;
  logic [292:0] st0;
  logic [127:0] a0, p0, c0, g0, et, eg;

  initial begin
    for (int i = 0; i < 4; i++) begin
      vt[i].st = rnd293();
      vt[i].ad = (i == 2) ? 128'h0 : rnd128();
      vt[i].tx = rnd128();
      vt[i].enc = (i % 2 == 0);
      model(vt[i].st, vt[i].ad, vt[i].tx, vt[i].enc, vt[i].et, vt[i].eg);
    end

    #12;
    chk("reset_state", {state_out, text_out, tag_out, busy_out, done_out} == '0,
        state_out, 293'(0));
    @(negedge clk) rst = 1'b0;

    // all-zero state: first AD step must shift in f = ~S107 = 1, or 0 when ad[0]=1
    @(negedge clk);
    state_in = '0; ad_in = '0; text_in = '0; encrypt_in = 1'b1; start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    chk("zero_load", state_out == '0, state_out, 293'(0));
    @(posedge clk); #1;
    chk("zero_step", state_out == {1'b1, 292'b0}, state_out, {1'b1, 292'b0});
    rst = 1'b1; #2 rst = 1'b0;
    @(negedge clk);
    ad_in = 128'h1; start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    @(posedge clk); #1;
    chk("zero_step_ad1", state_out == '0, state_out, 293'(0));
    rst = 1'b1; #2 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run(vt[i].st, vt[i].ad, vt[i].tx, vt[i].enc, -1, -1, lat);
      chk($sformatf("vec%0d_lat", i), lat == 1536, 293'(lat), 293'(1536));
      chk($sformatf("vec%0d_text", i), text_out == vt[i].et, 293'(text_out), 293'(vt[i].et));
      chk($sformatf("vec%0d_tag", i), tag_out == vt[i].eg, 293'(tag_out), 293'(vt[i].eg));
    end
    repeat (20) @(posedge clk);
    #1;
    chk("hold_done", done_out == 1'b1, 293'(done_out), 293'(1));
    chk("hold_tag", tag_out == vt[3].eg, 293'(tag_out), 293'(vt[3].eg));

    st0 = rnd293(); a0 = rnd128(); p0 = rnd128();
    run(st0, a0, p0, 1'b1, -1, -1, lat);
    c0 = text_out; g0 = tag_out;
    model(st0, a0, p0, 1'b1, et, eg);
    chk("rt_enc_text", c0 == et, 293'(c0), 293'(et));
    run(st0, a0, c0, 1'b0, -1, -1, lat);
    chk("rt_dec_text", text_out == p0, 293'(text_out), 293'(p0));
    chk("rt_dec_tag", tag_out == g0, 293'(tag_out), 293'(g0));

    run(st0, a0 ^ {1'b1, 127'b0}, p0, 1'b1, -1, -1, lat);
    chk("sens_ad127", tag_out != g0, 293'(tag_out), 293'(g0));
    run(st0, a0, p0 ^ 128'h1, 1'b1, -1, -1, lat);
    chk("sens_text0", tag_out != g0, 293'(tag_out), 293'(g0));
    run(st0, a0, p0, 1'b1, -1, -1, lat);
    chk("repeat_text", text_out == c0, 293'(text_out), 293'(c0));
    chk("repeat_tag", tag_out == g0, 293'(tag_out), 293'(g0));

    run(st0, a0, p0, 1'b1, 500, -1, lat);
    chk("poke_lat", lat == 1536, 293'(lat), 293'(1536));
    chk("poke_text", text_out == c0, 293'(text_out), 293'(c0));
    chk("poke_tag", tag_out == g0, 293'(tag_out), 293'(g0));

    run(st0, a0, p0, 1'b1, -1, 1000, lat);
    chk("abort_flag", lat == -1, 293'(lat), 293'(0));
    run(st0, a0, p0, 1'b1, -1, -1, lat);
    chk("after_rst_lat", lat == 1536, 293'(lat), 293'(1536));
    chk("after_rst_text", text_out == c0, 293'(text_out), 293'(c0));
    chk("after_rst_tag", tag_out == g0, 293'(tag_out), 293'(g0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
